incubator: RTL and testbench



---
 rtl/incubator.sv | 101 ++++++++++
 tb/tb_incubator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/incubator.sv
// Incubator temperature controller: registered Moore FSM with hysteresis bands
// driving heater, cooler and cooler fan speed from a signed temperature sample.
module incubator #(
    parameter logic signed [7:0] T_HEAT_ON  = 8'sd15,
    parameter logic signed [7:0] T_HEAT_OFF = 8'sd30,
    parameter logic signed [7:0] T_COOL_ON  = 8'sd35,
    parameter logic signed [7:0] T_COOL_OFF = 8'sd25,
    parameter logic signed [7:0] T_FAN_UP1  = 8'sd40,
    parameter logic signed [7:0] T_FAN_UP2  = 8'sd45,
    parameter logic signed [7:0] T_FAN_DN2  = 8'sd35,
    parameter logic signed [7:0] T_FAN_DN1  = 8'sd30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] t,
    output logic              cooler,
    output logic              heater,
    output logic        [3:0] rps
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHeat  = 3'd1,
        StCool4 = 3'd2,
        StCool6 = 3'd3,
        StCool8 = 3'd4
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One band step per edge; strict compares so equality always holds state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (t < T_HEAT_ON) begin
                    state_d = StHeat;
                end else if (t > T_COOL_ON) begin
                    state_d = StCool4;
                end
            end
            StHeat: begin
                if (t > T_HEAT_OFF) begin
                    state_d = StIdle;
                end
            end
            StCool4: begin
                if (t > T_FAN_UP1) begin
                    state_d = StCool6;
                end else if (t < T_COOL_OFF) begin
                    state_d = StIdle;
                end
            end
            StCool6: begin
                if (t > T_FAN_UP2) begin
                    state_d = StCool8;
                end else if (t < T_FAN_DN1) begin
                    state_d = StCool4;
                end
            end
            StCool8: begin
                if (t < T_FAN_DN2) begin
                    state_d = StCool6;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on the state register only; illegal encodings drive all-off.
    always_comb begin
        heater = 1'b0;
        cooler = 1'b0;
        rps    = 4'd0;
        case (state_q)
            StHeat: heater = 1'b1;
            StCool4: begin
                cooler = 1'b1;
                rps    = 4'd4;
            end
            StCool6: begin
                cooler = 1'b1;
                rps    = 4'd6;
            end
            StCool8: begin
                cooler = 1'b1;
                rps    = 4'd8;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_incubator.sv
// Directed bench for incubator: each task drives one scenario and checks
// {heater, cooler, rps} against hand-computed values.
module tb_incubator;

    logic              clk;
    logic              rst;
    logic signed [7:0] t;
    logic              cooler;
    logic              heater;
    logic        [3:0] rps;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] OIdle  = 6'b0_0_0000;
    localparam logic [5:0] OHeat  = 6'b1_0_0000;
    localparam logic [5:0] OCool4 = 6'b0_1_0100;
    localparam logic [5:0] OCool6 = 6'b0_1_0110;
    localparam logic [5:0] OCool8 = 6'b0_1_1000;

    incubator dut (
        .clk    (clk),
        .rst    (rst),
        .t      (t),
        .cooler (cooler),
        .heater (heater),
        .rps    (rps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive t mid-cycle, then land just after the next rising edge.
    task automatic step(input logic signed [7:0] v);
        @(negedge clk);
        t = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        t   = 8'sd22;
        #1;
        n_cmp++;
        if ({heater, cooler, rps} !== OIdle) begin
            n_bad++;
            $display("FAIL reset_held: got %b want %b", {heater, cooler, rps}, OIdle);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(8'sd22);
            n_cmp++;
            if ({heater, cooler, rps} !== OIdle) begin
                n_bad++;
                $display("FAIL reset_release_%0d: got %b want %b", i,
                         {heater, cooler, rps}, OIdle);
            end
        end
    endtask

    task automatic test_heat();
        logic signed [7:0] tv [6] = '{-8'sd9, -8'sd4, 8'sd10, 8'sd23, 8'sd30, 8'sd33};
        logic        [5:0] ev [6] = '{OHeat, OHeat, OHeat, OHeat, OHeat, OIdle};
        for (int i = 0; i < 6; i++) begin
            step(tv[i]);
            n_cmp++;
            if ({heater, cooler, rps} !== ev[i]) begin
                n_bad++;
                $display("FAIL heat_%0d t=%0d: got %b want %b", i, tv[i],
                         {heater, cooler, rps}, ev[i]);
            end
        end
    endtask

    task automatic test_fan_up();
        logic signed [7:0] tv [3] = '{8'sd36, 8'sd42, 8'sd55};
        logic        [5:0] ev [3] = '{OCool4, OCool6, OCool8};
        for (int i = 0; i < 3; i++) begin
            step(tv[i]);
            n_cmp++;
            if ({heater, cooler, rps} !== ev[i]) begin
                n_bad++;
                $display("FAIL fan_up_%0d t=%0d: got %b want %b", i, tv[i],
                         {heater, cooler, rps}, ev[i]);
            end
        end
    endtask

    task automatic test_fan_down();
        logic signed [7:0] tv [5] = '{8'sd39, 8'sd30, 8'sd30, 8'sd29, 8'sd24};
        logic        [5:0] ev [5] = '{OCool8, OCool6, OCool6, OCool4, OIdle};
        for (int i = 0; i < 5; i++) begin
            step(tv[i]);
            n_cmp++;
            if ({heater, cooler, rps} !== ev[i]) begin
                n_bad++;
                $display("FAIL fan_down_%0d t=%0d: got %b want %b", i, tv[i],
                         {heater, cooler, rps}, ev[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic signed [7:0] tv [9] = '{8'sd15, 8'sd35, 8'sd36, 8'sd25, 8'sd40, 8'sd41,
                                      8'sd45, 8'sd46, 8'sd35};
        logic        [5:0] ev [9] = '{OIdle, OIdle, OCool4, OCool4, OCool4, OCool6,
                                      OCool6, OCool8, OCool8};
        for (int i = 0; i < 9; i++) begin
            step(tv[i]);
            n_cmp++;
            if ({heater, cooler, rps} !== ev[i]) begin
                n_bad++;
                $display("FAIL boundary_%0d t=%0d: got %b want %b", i, tv[i],
                         {heater, cooler, rps}, ev[i]);
            end
        end
    endtask

    // Starts in COOL8 (left by test_boundaries); walks one state per edge.
    task automatic test_stepping();
        logic signed [7:0] tv [5] = '{-8'sd20, -8'sd20, -8'sd20, -8'sd20, 8'sd31};
        logic        [5:0] ev [5] = '{OCool6, OCool4, OIdle, OHeat, OIdle};
        for (int i = 0; i < 5; i++) begin
            step(tv[i]);
            n_cmp++;
            if ({heater, cooler, rps} !== ev[i]) begin
                n_bad++;
                $display("FAIL stepping_%0d t=%0d: got %b want %b", i, tv[i],
                         {heater, cooler, rps}, ev[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        step(8'sd36);
        step(8'sd41);
        n_cmp++;
        if ({heater, cooler, rps} !== OCool6) begin
            n_bad++;
            $display("FAIL async_setup: got %b want %b", {heater, cooler, rps}, OCool6);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({heater, cooler, rps} !== OIdle) begin
            n_bad++;
            $display("FAIL async_immediate: got %b want %b", {heater, cooler, rps}, OIdle);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({heater, cooler, rps} !== OIdle) begin
            n_bad++;
            $display("FAIL async_held: got %b want %b", {heater, cooler, rps}, OIdle);
        end
        @(negedge clk);
        rst = 1'b0;
        t   = 8'sd22;
        step(8'sd22);
        n_cmp++;
        if ({heater, cooler, rps} !== OIdle) begin
            n_bad++;
            $display("FAIL async_resume_idle: got %b want %b", {heater, cooler, rps}, OIdle);
        end
        step(8'sd36);
        n_cmp++;
        if ({heater, cooler, rps} !== OCool4) begin
            n_bad++;
            $display("FAIL async_resume_cool4: got %b want %b", {heater, cooler, rps},
                     OCool4);
        end
    endtask

    initial begin
        rst = 1'b1;
        t   = 8'sd22;
        test_reset();
        test_heat();
        test_fan_up();
        test_fan_down();
        test_boundaries();
        test_stepping();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
